// File: rtl/io_pinmux_pkg.sv
// io_pinmux_pkg: register map, function-select type and byte-strobe helper
// shared by the pad function controller.
package io_pinmux_pkg;

    localparam int FSEL_W = 2;

    typedef logic [FSEL_W-1:0] fsel_t;

    localparam fsel_t FUNC_GPIO = 2'd0;

    localparam logic [7:0] OFF_GPIO_OUT = 8'h00;
    localparam logic [7:0] OFF_GPIO_OE  = 8'h04;
    localparam logic [7:0] OFF_GPIO_IN  = 8'h08;
    localparam logic [7:0] OFF_FSEL     = 8'h0C;
    localparam logic [7:0] OFF_RISE_EN  = 8'h10;
    localparam logic [7:0] OFF_FALL_EN  = 8'h14;
    localparam logic [7:0] OFF_IRQ_PEND = 8'h18;

    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage

// File: rtl/io_pinmux_if.sv
// io_pinmux_if: native memory bus between the core and the pinmux registers.
// The slave acknowledges each request with a one-cycle ready pulse.
interface io_pinmux_if;

    logic        mem_valid;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/io_pad_sync.sv
// io_pad_sync: three-flop synchroniser for pad inputs with edge pulses
// derived from the last two synchronised stages.
module io_pad_sync
    import io_pinmux_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o,
    output logic [W-1:0] rise_o,
    output logic [W-1:0] fall_o
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;
    logic [W-1:0] s3_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign q_o    = s2_q;
    assign rise_o = s2_q & ~s3_q;
    assign fall_o = ~s2_q & s3_q;

endmodule

// File: rtl/io_pinmux_ctrl.sv
// io_pinmux_ctrl: pad function controller with GPIO registers, per-pad
// function mux towards the pad ring and edge interrupts.
module io_pinmux_ctrl
    import io_pinmux_pkg::*;
#(
    parameter int   NUM_PAD  = 16,
    parameter int   NUM_FUNC = 4,
    parameter logic IDLE_VAL = 1'b1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    io_pinmux_if.slave                      mem,
    output logic [NUM_PAD-1:0]              pad_c2p_o,
    output logic [NUM_PAD-1:0]              pad_c2p_en_o,
    input  logic [NUM_PAD-1:0]              pad_p2c_i,
    input  logic [(NUM_FUNC-1)*NUM_PAD-1:0] per_c2p_i,
    input  logic [(NUM_FUNC-1)*NUM_PAD-1:0] per_oe_i,
    output logic [(NUM_FUNC-1)*NUM_PAD-1:0] per_p2c_o,
    output logic                            irq_o
);

    localparam logic [31:0] PAD_MASK =
        32'((64'd1 << NUM_PAD) - 64'd1);
    localparam logic [31:0] FSEL_MASK =
        32'((64'd1 << (FSEL_W * NUM_PAD)) - 64'd1);

    logic        ack_q;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] gpio_out_q, gpio_out_d;
    logic [31:0] gpio_oe_q, gpio_oe_d;
    logic [31:0] fsel_q, fsel_d;
    logic [31:0] rise_en_q, rise_en_d;
    logic [31:0] fall_en_q, fall_en_d;
    logic [31:0] pend_q, pend_d;
    logic [31:0] pend_clr;
    logic        irq_q;

    logic               req;
    logic               wr;
    logic [7:0]         off;
    logic [31:0]        wmask;
    logic [31:0]        wbits;
    logic [NUM_PAD-1:0] sync_in;
    logic [NUM_PAD-1:0] rise;
    logic [NUM_PAD-1:0] fall;
    logic               unused_addr;

    io_pad_sync #(.W(NUM_PAD)) u_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (pad_p2c_i),
        .q_o    (sync_in),
        .rise_o (rise),
        .fall_o (fall)
    );

    // A request seen during the ack cycle is only accepted one cycle later.
    assign req   = mem.mem_valid & ~ack_q;
    assign wr    = req & (|mem.mem_wstrb);
    assign off   = {mem.mem_addr[7:2], 2'b00};
    assign wmask = strb_mask(mem.mem_wstrb);
    assign wbits = mem.mem_wdata & wmask;

    assign unused_addr = ^mem.mem_addr[1:0];

    always_comb begin
        gpio_out_d = gpio_out_q;
        gpio_oe_d  = gpio_oe_q;
        fsel_d     = fsel_q;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        pend_clr   = '0;
        if (wr) begin
            unique case (off)
                OFF_GPIO_OUT: gpio_out_d = ((gpio_out_q & ~wmask) | wbits) & PAD_MASK;
                OFF_GPIO_OE:  gpio_oe_d  = ((gpio_oe_q & ~wmask) | wbits) & PAD_MASK;
                OFF_FSEL:     fsel_d     = ((fsel_q & ~wmask) | wbits) & FSEL_MASK;
                OFF_RISE_EN:  rise_en_d  = ((rise_en_q & ~wmask) | wbits) & PAD_MASK;
                OFF_FALL_EN:  fall_en_d  = ((fall_en_q & ~wmask) | wbits) & PAD_MASK;
                OFF_IRQ_PEND: pend_clr   = wbits;
                default: ;
            endcase
        end
        // Set terms are OR-ed after the clear so a fresh edge survives W1C.
        pend_d = ((pend_q & ~pend_clr)
                 | 32'((rise & rise_en_q[NUM_PAD-1:0])
                 | (fall & fall_en_q[NUM_PAD-1:0]))) & PAD_MASK;
    end

    always_comb begin
        rdata_d = '0;
        unique case (off)
            OFF_GPIO_OUT: rdata_d = gpio_out_q;
            OFF_GPIO_OE:  rdata_d = gpio_oe_q;
            OFF_GPIO_IN:  rdata_d = 32'(sync_in);
            OFF_FSEL:     rdata_d = fsel_q;
            OFF_RISE_EN:  rdata_d = rise_en_q;
            OFF_FALL_EN:  rdata_d = fall_en_q;
            OFF_IRQ_PEND: rdata_d = pend_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            gpio_out_q <= '0;
            gpio_oe_q  <= '0;
            fsel_q     <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            pend_q     <= '0;
            irq_q      <= 1'b0;
        end else begin
            ack_q      <= req;
            rdata_q    <= req ? rdata_d : '0;
            gpio_out_q <= gpio_out_d;
            gpio_oe_q  <= gpio_oe_d;
            fsel_q     <= fsel_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            pend_q     <= pend_d;
            irq_q      <= |pend_q;
        end
    end

    assign mem.mem_ready = ack_q;
    assign mem.mem_rdata = rdata_q;
    assign irq_o         = irq_q;

    for (genvar p = 0; p < NUM_PAD; p++) begin : g_pad
        fsel_t sel;
        logic  c2p;
        logic  en;

        assign sel = fsel_q[FSEL_W*p +: FSEL_W];

        always_comb begin
            c2p = 1'b0;
            en  = 1'b0;
            if (sel == FUNC_GPIO) begin
                c2p = gpio_out_q[p];
                en  = gpio_oe_q[p];
            end
            for (int k = 1; k < NUM_FUNC; k++) begin
                if (sel == FSEL_W'(k)) begin
                    c2p = per_c2p_i[(k-1)*NUM_PAD+p];
                    en  = per_oe_i[(k-1)*NUM_PAD+p];
                end
            end
        end

        assign pad_c2p_o[p]    = c2p;
        assign pad_c2p_en_o[p] = en;

        for (genvar k = 1; k < NUM_FUNC; k++) begin : g_fn
            assign per_p2c_o[(k-1)*NUM_PAD+p] =
                (sel == FSEL_W'(k)) ? pad_p2c_i[p] : IDLE_VAL;
        end
    end

endmodule

// File: tb/tb_io_pinmux_ctrl.sv
// tb_io_pinmux_ctrl: directed and randomized checks of the pinmux against
// a register-level reference model.
module tb_io_pinmux_ctrl;

    localparam int NP = 16;
    localparam int NF = 4;
    localparam int PW = (NF-1)*NP;
    localparam logic [31:0] PADM = 32'h0000_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    io_pinmux_if bus();

    logic [NP-1:0] pad_c2p, pad_en, pad_p2c;
    logic [PW-1:0] per_c2p, per_oe, per_p2c;
    logic          irq;

    io_pinmux_ctrl #(
        .NUM_PAD  (NP),
        .NUM_FUNC (NF),
        .IDLE_VAL (1'b1)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .mem          (bus),
        .pad_c2p_o    (pad_c2p),
        .pad_c2p_en_o (pad_en),
        .pad_p2c_i    (pad_p2c),
        .per_c2p_i    (per_c2p),
        .per_oe_i     (per_oe),
        .per_p2c_o    (per_p2c),
        .irq_o        (irq)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] m_out, m_oe, m_fsel, m_rise, m_fall, m_pend;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] wd,
                                          input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic m_reset();
        m_out = 0; m_oe = 0; m_fsel = 0;
        m_rise = 0; m_fall = 0; m_pend = 0;
    endtask

    task automatic m_write(input logic [7:0] a, input logic [31:0] wd,
                           input logic [3:0] st);
        case (a)
            8'h00: m_out  = merge(m_out, wd, st) & PADM;
            8'h04: m_oe   = merge(m_oe, wd, st) & PADM;
            8'h0C: m_fsel = merge(m_fsel, wd, st);
            8'h10: m_rise = merge(m_rise, wd, st) & PADM;
            8'h14: m_fall = merge(m_fall, wd, st) & PADM;
            8'h18: m_pend = m_pend & ~merge(32'h0, wd, st);
            default: ;
        endcase
    endtask

    // Pads are held stable long before any read, so GPIO_IN equals pad_p2c.
    function automatic logic [31:0] m_read(input logic [7:0] a);
        case (a)
            8'h00: return m_out;
            8'h04: return m_oe;
            8'h08: return 32'(pad_p2c);
            8'h0C: return m_fsel;
            8'h10: return m_rise;
            8'h14: return m_fall;
            8'h18: return m_pend;
            default: return 32'h0;
        endcase
    endfunction

    task automatic xfer(input logic [7:0] a, input logic [31:0] wd,
                        input logic [3:0] st, output logic [31:0] rd);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = a;
        bus.mem_wdata = wd;
        bus.mem_wstrb = st;
        chk("ack_early", bus.mem_ready, 0);
        @(posedge clk); #1;
        chk("ack", bus.mem_ready, 1);
        rd = bus.mem_rdata;
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'h0;
        @(posedge clk); #1;
        chk("ack_pulse", bus.mem_ready, 0);
        chk("rdata_idle", bus.mem_rdata, 0);
    endtask

    task automatic do_wr(input logic [7:0] a, input logic [31:0] wd,
                         input logic [3:0] st);
        logic [31:0] rd;
        xfer(a, wd, st, rd);
        m_write(a, wd, st);
    endtask

    task automatic do_rd(input logic [7:0] a, input string tag);
        logic [31:0] rd;
        xfer(a, 32'h0, 4'h0, rd);
        chk(tag, rd, m_read(a));
    endtask

    task automatic set_pads(input logic [NP-1:0] nv);
        logic [NP-1:0] ov;
        ov = pad_p2c;
        pad_p2c = nv;
        repeat (4) @(posedge clk);
        #1;
        m_pend = m_pend | ((32'(~ov & nv) & m_rise)
                         | (32'(ov & ~nv) & m_fall));
    endtask

    task automatic check_pins();
        logic [NP-1:0] ec, ee;
        logic [PW-1:0] ep;
        int s;
        ep = '1;
        for (int p = 0; p < NP; p++) begin
            s = int'((m_fsel >> (2*p)) & 32'h3);
            if (s == 0) begin
                ec[p] = m_out[p];
                ee[p] = m_oe[p];
            end else begin
                ec[p] = per_c2p[(s-1)*NP+p];
                ee[p] = per_oe[(s-1)*NP+p];
                ep[(s-1)*NP+p] = pad_p2c[p];
            end
        end
        chk("pad_c2p", pad_c2p, ec);
        chk("pad_en", pad_en, ee);
        chk("per_p2c", per_p2c, ep);
        chk("irq", irq, |m_pend);
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  a;
        bus.mem_valid = 1'b0;
        bus.mem_addr  = 8'h0;
        bus.mem_wdata = 32'h0;
        bus.mem_wstrb = 4'h0;
        per_c2p = '0;
        per_oe  = '0;
        pad_p2c = 16'h1234;
        m_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_en", pad_en, 0);
        chk("rst_c2p", pad_c2p, 0);
        chk("rst_irq", irq, 0);
        chk("rst_per_p2c", per_p2c, {PW{1'b1}});
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++)
            do_rd(8'(4*i), "rst_read");

        set_pads(16'h0000);

        do_wr(8'h04, 32'h0000_00FF, 4'hF);
        do_wr(8'h00, 32'h0000_00A5, 4'hF);
        chk("oe_ff", pad_en, 16'h00FF);
        chk("out_a5", pad_c2p[7:0], 8'hA5);
        check_pins();

        do_wr(8'h0C, 32'h0000_0004, 4'hF);
        per_c2p[1] = 1'b1;
        per_oe[1]  = 1'b1;
        #1;
        chk("pad1_c2p", pad_c2p[1], 1);
        chk("pad1_en", pad_en[1], 1);
        check_pins();
        pad_p2c[1] = 1'b1;
        #1 chk("p2c_hi", per_p2c[1], 1);
        pad_p2c[1] = 1'b0;
        #1 chk("p2c_lo", per_p2c[1], 0);

        do_wr(8'h10, 32'h1, 4'hF);
        pad_p2c[0] = 1'b1;
        for (int e = 0; e < 3; e++) begin
            @(posedge clk); #1;
            chk("irq_lat_lo", irq, 0);
        end
        @(posedge clk); #1;
        chk("irq_lat_hi", irq, 1);
        m_pend = m_pend | 32'h1;
        do_rd(8'h18, "pend_set");
        do_wr(8'h18, 32'h1, 4'hF);
        chk("irq_clr", irq, 0);
        do_rd(8'h18, "pend_clr");

        set_pads(16'h0000);
        pad_p2c[0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 8'h18;
        bus.mem_wdata = 32'h1;
        bus.mem_wstrb = 4'hF;
        @(posedge clk); #1;
        chk("w1c_ack", bus.mem_ready, 1);
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'h0;
        @(posedge clk); #1;
        m_pend = m_pend | 32'h1;
        do_rd(8'h18, "set_wins");
        chk("set_wins_irq", irq, 1);
        do_wr(8'h18, 32'h1, 4'hF);
        set_pads(16'h0000);
        do_rd(8'h18, "fall_ignored");

        do_wr(8'h00, 32'hFFFF_FFFF, 4'b0010);
        do_rd(8'h00, "strb_byte1");
        do_rd(8'h1C, "unmapped");

        for (int it = 0; it < 150; it++) begin
            set_pads(NP'($urandom));
            per_c2p = PW'({$urandom, $urandom});
            per_oe  = PW'({$urandom, $urandom});
            #1;
            a = 8'(4 * $urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1)
                do_wr(a, $urandom, 4'($urandom_range(1, 15)));
            else
                do_rd(a, "rand_read");
            check_pins();
        end

        do_wr(8'h18, 32'hFFFF_FFFF, 4'hF);
        do_wr(8'h04, 32'hFFFF, 4'hF);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 8'h00;
        bus.mem_wdata = 32'hFFFF;
        bus.mem_wstrb = 4'hF;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_no_ack", bus.mem_ready, 0);
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'h0;
        @(posedge clk); #1;
        chk("rst_no_ack2", bus.mem_ready, 0);
        rst = 1'b0;
        m_reset();
        chk("rst2_en", pad_en, 0);
        chk("rst2_c2p", pad_c2p, 0);
        chk("rst2_irq", irq, 0);
        chk("rst2_per", per_p2c, {PW{1'b1}});
        repeat (3) @(posedge clk);
        #1;
        do_rd(8'h00, "rst2_out");
        do_rd(8'h04, "rst2_oe");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
